// File: rtl/peridot_cam_pkg.sv
// Shared definitions for the peridot camera pixel packer: FSM state encoding and pixel/burst geometry.
// ST_PAD is only part of the encoding when PERIDOT_CAM_FRAME_PAD_EN is defined.
package peridot_cam_pkg;

    localparam int BURST_WORDS = 16;
    localparam int PIX_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
`ifdef PERIDOT_CAM_FRAME_PAD_EN
        ST_PAD     = 2'd2,
`endif
        ST_CAPTURE = 2'd1
    } cam_state_t;

    // The first pixel of a pair occupies the low half-word.
    function automatic logic [2*PIX_W-1:0] pack_pair(input logic [PIX_W-1:0] hi,
                                                     input logic [PIX_W-1:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/peridot_cam_wordfifo.sv
// Single-clock show-ahead word FIFO on an inferred RAM; exposes the registered level and full/empty flags.
module peridot_cam_wordfifo #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 32
) (
    input  logic                  avm_clk_sig,
    input  logic                  reset_sig,
    input  logic                  clear,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = level[DEPTH_LOG2];
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: the storage array has no reset so it maps onto RAM; the pointers alone define what is valid.
    always_ff @(posedge avm_clk_sig) begin
        if (do_push && !clear)
            mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

    // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge avm_clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            level <= level + {{DEPTH_LOG2{1'b0}}, do_push} - {{DEPTH_LOG2{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/peridot_cam_pack_fifo.sv
// Packs RGB565 pixel pairs into 32-bit words and buffers them for an Avalon-MM burst writer.
// Define PERIDOT_CAM_FRAME_PAD_EN to pad every frame with zero words up to a 16-word burst boundary.
module peridot_cam_pack_fifo
    import peridot_cam_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 6
) (
    input  logic                       avm_clk_sig,
    input  logic                       reset_sig,
    input  logic                       init,
    input  logic                       enable,
    input  logic                       pix_valid,
    input  logic [15:0]                pix_data,
    input  logic                       pix_eof,
    output logic                       writedata_ready,
    output logic [31:0]                writedata,
    input  logic                       writedata_rdack,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam logic [FIFO_DEPTH_LOG2:0] BURST_LEVEL = (FIFO_DEPTH_LOG2+1)'(BURST_WORDS);

    cam_state_t         state;
    logic               half_valid;
    logic [PIX_W-1:0]   half_data;
    logic               push_req;
    logic [31:0]        push_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               capturing;
    logic               cap_push;
    logic [31:0]        cap_word;
    logic               drop_word;

    assign capturing       = (state == ST_CAPTURE) && enable;
    assign writedata_ready = (fifo_level >= BURST_LEVEL);

    // Word produced by this cycle's pixel/eof: a pixel is packed before a coincident eof is applied.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cap_push = 1'b0;
        cap_word = pack_pair('0, half_data);
        if (pix_valid && half_valid) begin
            cap_push = 1'b1;
            cap_word = pack_pair(pix_data, half_data);
        end else if (pix_valid && pix_eof) begin
            cap_push = 1'b1;
            cap_word = pack_pair('0, pix_data);
        end else if (!pix_valid && pix_eof && half_valid) begin
            cap_push = 1'b1;
        end
    end

`ifdef PERIDOT_CAM_FRAME_PAD_EN
    localparam int FRAME_CNT_W = $clog2(BURST_WORDS);

    logic                   push_pad;
    logic                   push_hold;
    logic                   pad_issue;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    // Padding words wait for room instead of being dropped.
    assign push_hold = push_req && push_pad && fifo_full;
    assign pad_issue = (state == ST_PAD) && !push_hold && (frame_cnt != '0);
    assign drop_word = push_req && !push_pad && fifo_full;

    // Words issued this frame, modulo the burst length.
    always_ff @(posedge avm_clk_sig or posedge reset_sig) begin
        if (reset_sig)
            frame_cnt <= '0;
        else if (init || state == ST_IDLE)
            frame_cnt <= '0;
        else if ((capturing && cap_push) || pad_issue)
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
    end
`else
    assign drop_word = push_req && fifo_full;
`endif

    always_ff @(posedge avm_clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state      <= ST_IDLE;
            half_valid <= 1'b0;
            half_data  <= '0;
            push_req   <= 1'b0;
            push_data  <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
`ifdef PERIDOT_CAM_FRAME_PAD_EN
            push_pad   <= 1'b0;
`endif
        end else if (init) begin
            state      <= ST_IDLE;
            half_valid <= 1'b0;
            push_req   <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
`ifdef PERIDOT_CAM_FRAME_PAD_EN
            push_pad   <= 1'b0;
`endif
        end else begin
            push_req <= 1'b0;
`ifdef PERIDOT_CAM_FRAME_PAD_EN
            push_pad <= 1'b0;
`endif
            if (drop_word)
                overflow <= 1'b1;
            if (writedata_rdack && fifo_empty)
                underflow <= 1'b1;

            case (state)
                ST_IDLE: begin
                    half_valid <= 1'b0;
                    if (enable)
                        state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (!enable) begin
                        state      <= ST_IDLE;
                        half_valid <= 1'b0;
                    end else begin
                        if (cap_push) begin
                            push_req  <= 1'b1;
                            push_data <= cap_word;
                        end
                        if (pix_valid && !half_valid)
                            half_data <= pix_data;
                        if (pix_valid)
                            half_valid <= !half_valid && !pix_eof;
                        else if (pix_eof)
                            half_valid <= 1'b0;
`ifdef PERIDOT_CAM_FRAME_PAD_EN
                        if (pix_eof)
                            state <= ST_PAD;
`endif
                    end
                end
`ifdef PERIDOT_CAM_FRAME_PAD_EN
                ST_PAD: begin
                    if (pix_valid)
                        overflow <= 1'b1;
                    if (push_hold) begin
                        push_req <= 1'b1;
                        push_pad <= 1'b1;
                    end else if (pad_issue) begin
                        push_req  <= 1'b1;
                        push_pad  <= 1'b1;
                        push_data <= '0;
                    end else begin
                        state <= enable ? ST_CAPTURE : ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    peridot_cam_wordfifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (32)
    ) u_wordfifo (
        .avm_clk_sig (avm_clk_sig),
        .reset_sig   (reset_sig),
        .clear       (init),
        .push        (push_req),
        .push_data   (push_data),
        .pop         (writedata_rdack),
        .head_data   (writedata),
        .level       (fifo_level),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

endmodule

// File: tb/tb_peridot_cam_pack_fifo.sv
// Directed scoreboard bench for peridot_cam_pack_fifo; follows PERIDOT_CAM_FRAME_PAD_EN when defined.
module tb_peridot_cam_pack_fifo;

    localparam int LOG2  = 6;
    localparam int DEPTH = 1 << LOG2;

    logic            avm_clk_sig = 1'b0;
    logic            reset_sig;
    logic            init;
    logic            enable;
    logic            pix_valid;
    logic [15:0]     pix_data;
    logic            pix_eof;
    logic            writedata_ready;
    logic [31:0]     writedata;
    logic            writedata_rdack;
    logic [LOG2:0]   fifo_level;
    logic            overflow;
    logic            underflow;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [31:0]     exp_q[$];
    logic            mh_valid;
    logic [15:0]     mh_data;
    int              m_frame;

    peridot_cam_pack_fifo #(.FIFO_DEPTH_LOG2(LOG2)) dut (
        .avm_clk_sig     (avm_clk_sig),
        .reset_sig       (reset_sig),
        .init            (init),
        .enable          (enable),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_eof         (pix_eof),
        .writedata_ready (writedata_ready),
        .writedata       (writedata),
        .writedata_rdack (writedata_rdack),
        .fifo_level      (fifo_level),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    always #5 avm_clk_sig = ~avm_clk_sig;

    task automatic tick();
        @(posedge avm_clk_sig);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_push(input logic [31:0] word);
        if (exp_q.size() < DEPTH)
            exp_q.push_back(word);
        m_frame++;
    endfunction

    function automatic void model_pad();
`ifdef PERIDOT_CAM_FRAME_PAD_EN
        while ((m_frame % 16) != 0)
            model_push(32'h0);
`endif
        m_frame = 0;
    endfunction

    task automatic send_pix(input logic [15:0] p, input logic eof);
        pix_valid = 1'b1;
        pix_data  = p;
        pix_eof   = eof;
        if (mh_valid) begin
            model_push({p, mh_data});
            mh_valid = 1'b0;
        end else if (eof) begin
            model_push({16'h0000, p});
        end else begin
            mh_data  = p;
            mh_valid = 1'b1;
        end
        tick();
        pix_valid = 1'b0;
        pix_eof   = 1'b0;
        if (eof)
            model_pad();
    endtask

    task automatic send_eof();
        pix_eof = 1'b1;
        if (mh_valid) begin
            model_push({16'h0000, mh_data});
            mh_valid = 1'b0;
        end
        tick();
        pix_eof = 1'b0;
        model_pad();
    endtask

    task automatic pop_check(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed pop request expected an empty scoreboard", tag);
        end else begin
            check(tag, writedata, exp_q.pop_front());
        end
        writedata_rdack = 1'b1;
        tick();
        writedata_rdack = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0)
            pop_check(tag);
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init     = 1'b0;
        mh_valid = 1'b0;
        m_frame  = 0;
        exp_q.delete();
        tick();
    endtask

    initial begin
        reset_sig       = 1'b1;
        init            = 1'b0;
        enable          = 1'b0;
        pix_valid       = 1'b0;
        pix_data        = '0;
        pix_eof         = 1'b0;
        writedata_rdack = 1'b0;
        mh_valid        = 1'b0;
        mh_data         = '0;
        m_frame         = 0;
        repeat (3) tick();
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(writedata_ready), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        reset_sig = 1'b0;
        tick();

        // Idle pixels are ignored and do not flag overflow.
        send_pix(16'h5555, 1'b0);
        mh_valid = 1'b0;
        check("idle_ignore_level", 32'(fifo_level), 32'd0);
        check("idle_ignore_ovf", 32'(overflow), 32'd0);

        // First pair: visible two cycles after the second pixel.
        enable = 1'b1;
        tick();
        send_pix(16'h1111, 1'b0);
        send_pix(16'h2222, 1'b0);
        tick();
        check("pair_level", 32'(fifo_level), 32'd1);
        pop_check("pair_word");
        check("pair_popped_level", 32'(fifo_level), 32'd0);

        // Sixteen words: writedata_ready follows the level crossing 16.
        for (int i = 0; i < 32; i++)
            send_pix(16'(16'hA000 + i), 1'b0);
        check("burst_level_15", 32'(fifo_level), 32'd15);
        check("burst_ready_low", 32'(writedata_ready), 32'd0);
        tick();
        check("burst_level_16", 32'(fifo_level), 32'd16);
        check("burst_ready_high", 32'(writedata_ready), 32'd1);

        // Push and pop on the same edge at level 16.
        send_pix(16'hBEEF, 1'b0);
        send_pix(16'hCAFE, 1'b0);
        pop_check("pushpop_word");
        check("pushpop_level", 32'(fifo_level), 32'd16);
        check("pushpop_ready", 32'(writedata_ready), 32'd1);
        drain("burst_drain");
        check("burst_empty_level", 32'(fifo_level), 32'd0);
        check("burst_empty_ready", 32'(writedata_ready), 32'd0);

        // Pop from empty FIFO.
        writedata_rdack = 1'b1;
        tick();
        writedata_rdack = 1'b0;
        check("underflow_flag", 32'(underflow), 32'd1);
        check("underflow_level", 32'(fifo_level), 32'd0);
        do_init();
        check("init_underflow", 32'(underflow), 32'd0);

        // Odd pixel count closed by eof (plus padding when enabled).
        send_pix(16'h0A01, 1'b0);
        send_pix(16'h0A02, 1'b0);
        send_pix(16'h0A03, 1'b0);
        send_eof();
        repeat (20) tick();
        check("eof_level", 32'(fifo_level), 32'(exp_q.size()));
        drain("eof_drain");

        // Pixel coinciding with eof is packed first.
        send_pix(16'hABCD, 1'b1);
        repeat (20) tick();
        check("eof_coincide_level", 32'(fifo_level), 32'(exp_q.size()));
        drain("eof_coincide_drain");
        check("eof_no_overflow", 32'(overflow), 32'd0);

        // Overflow: 130 pixels into a 64-word FIFO.
        for (int i = 0; i < 130; i++)
            send_pix(16'(16'h4000 + i), 1'b0);
        repeat (3) tick();
        check("ovf_level", 32'(fifo_level), 32'(DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_ready", 32'(writedata_ready), 32'd1);
        drain("ovf_drain");
        check("ovf_drained_level", 32'(fifo_level), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of a burst discards everything.
        for (int i = 0; i < 6; i++)
            send_pix(16'(16'h7000 + i), 1'b0);
        reset_sig = 1'b1;
        #1;
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        check("midrst_ready", 32'(writedata_ready), 32'd0);
        tick();
        reset_sig = 1'b0;
        exp_q.delete();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
